freelist_arbiter_2a2r: RTL and testbench

- Controller that shares one preloaded 1-write/1-read tag free-list FIFO between two allocating and two releasing requesters.
- Arbitrates pops and pushes, registers the granted tag, and tracks the number of outstanding tags.
- Provides a quiesce handshake that stops allocation until all tags have returned.
- Sits between the rename/issue-side requesters and the free-list FIFO instance (FIFO reset state full, contents 0..POOL_SIZE-1).

---
 rtl/freelist_arbiter_2a2r.sv | 86 ++++++++
 tb/tb_freelist_arbiter_2a2r.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/freelist_arbiter_2a2r.sv
// freelist_arbiter_2a2r: shares one preloaded tag free-list FIFO between two allocators and two releasers.
// Define FREELIST_ARBITER_ERRCHK_EN to add the err_sticky_o release-misuse flag.
module freelist_arbiter_2a2r #(
  parameter int TAG_WIDTH  = 6,
  parameter int DEPTH_LOG2 = 4,
  parameter int POOL_SIZE  = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
`ifdef FREELIST_ARBITER_ERRCHK_EN
  output logic                  err_sticky_o,
`endif
  input  logic [1:0]            alloc_req_i,
  output logic [1:0]            alloc_vld_o,
  output logic [TAG_WIDTH-1:0]  alloc_tag_o,
  input  logic [1:0]            rel_req_i,
  input  logic [TAG_WIDTH-1:0]  rel_tag0_i,
  input  logic [TAG_WIDTH-1:0]  rel_tag1_i,
  output logic [1:0]            rel_ack_o,
  input  logic                  quiesce_req_i,
  output logic                  quiesce_done_o,
  output logic [DEPTH_LOG2:0]   outstanding_o,
  input  logic [TAG_WIDTH-1:0]  fifo_dout_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_full_i,
  output logic                  fifo_ren_o,
  output logic [TAG_WIDTH-1:0]  fifo_din_o,
  output logic                  fifo_wen_o
);
  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_e;
  localparam logic [DEPTH_LOG2:0] POOL = POOL_SIZE[DEPTH_LOG2:0];
  state_e                 state_q, state_d;
  logic [1:0]             alloc_vld_q;
  logic [TAG_WIDTH-1:0]   alloc_tag_q;
  logic [DEPTH_LOG2:0]    outstanding_q, outstanding_d;
  logic                   quiesce_done_q;
  logic                   a_ptr_q, r_ptr_q;
  logic                   a_win, r_win, a_go, r_go;
  always_comb begin
    a_win = alloc_req_i[a_ptr_q] ? a_ptr_q : ~a_ptr_q;
    r_win = rel_req_i[r_ptr_q] ? r_ptr_q : ~r_ptr_q;
    a_go  = state_q == RUN && !quiesce_req_i && !fifo_empty_i && |alloc_req_i;
    r_go  = |rel_req_i && !fifo_full_i;
    outstanding_d = (a_go && !r_go && outstanding_q != POOL) ? outstanding_q + 1'b1 :
                    (r_go && !a_go && outstanding_q != '0) ? outstanding_q - 1'b1 : outstanding_q;
    // a pop in flight would re-raise outstanding, so DRAIN only settles with no pop
    state_d = state_q == RUN   ? (quiesce_req_i ? DRAIN : RUN) :
              state_q == DRAIN ? (!quiesce_req_i ? RUN : (outstanding_q == '0 && !a_go) ? IDLE : DRAIN) :
                                 (quiesce_req_i ? IDLE : RUN);
  end
  assign fifo_ren_o     = a_go;
  assign fifo_wen_o     = r_go;
  assign fifo_din_o     = !r_go ? '0 : r_win ? rel_tag1_i : rel_tag0_i;
  assign rel_ack_o      = !r_go ? 2'b00 : r_win ? 2'b10 : 2'b01;
  assign alloc_vld_o    = alloc_vld_q;
  assign alloc_tag_o    = alloc_tag_q;
  assign outstanding_o  = outstanding_q;
  assign quiesce_done_o = quiesce_done_q;
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q        <= RUN;
      alloc_vld_q    <= 2'b00;
      alloc_tag_q    <= '0;
      outstanding_q  <= '0;
      quiesce_done_q <= 1'b0;
      a_ptr_q        <= 1'b0;
      r_ptr_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      alloc_vld_q    <= !a_go ? 2'b00 : a_win ? 2'b10 : 2'b01;
      alloc_tag_q    <= a_go ? fifo_dout_i : alloc_tag_q;
      outstanding_q  <= outstanding_d;
      quiesce_done_q <= state_d == IDLE;
      a_ptr_q        <= a_go ? ~a_win : a_ptr_q;
      r_ptr_q        <= r_go ? ~r_win : r_ptr_q;
    end
  end
`ifdef FREELIST_ARBITER_ERRCHK_EN
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (!resetn_i) err_q <= 1'b0;
    else if ((|rel_req_i && fifo_full_i) || (r_go && outstanding_q == '0)) err_q <= 1'b1;
  end
  assign err_sticky_o = err_q;
`endif
endmodule

// File: tb/tb_freelist_arbiter_2a2r.sv
// tb_freelist_arbiter_2a2r: directed checks of the arbiter against a small behavioural free-list FIFO.
module tb_freelist_arbiter_2a2r;
  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] alloc_req, alloc_vld, rel_req, rel_ack;
  logic [5:0] alloc_tag, rel_tag0, rel_tag1, fifo_dout, fifo_din;
  logic       quiesce_req, quiesce_done, fifo_empty, fifo_full, fifo_ren, fifo_wen;
  logic [4:0] outstanding;
`ifdef FREELIST_ARBITER_ERRCHK_EN
  logic       err_sticky;
`endif
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  freelist_arbiter_2a2r dut (
    .clk_i(clk), .resetn_i(resetn),
`ifdef FREELIST_ARBITER_ERRCHK_EN
    .err_sticky_o(err_sticky),
`endif
    .alloc_req_i(alloc_req), .alloc_vld_o(alloc_vld), .alloc_tag_o(alloc_tag),
    .rel_req_i(rel_req), .rel_tag0_i(rel_tag0), .rel_tag1_i(rel_tag1), .rel_ack_o(rel_ack),
    .quiesce_req_i(quiesce_req), .quiesce_done_o(quiesce_done), .outstanding_o(outstanding),
    .fifo_dout_i(fifo_dout), .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full),
    .fifo_ren_o(fifo_ren), .fifo_din_o(fifo_din), .fifo_wen_o(fifo_wen)
  );
  // free-list FIFO: resets full with tags 0..15, show-ahead head
  logic [5:0] mem [16];
  logic [3:0] rp, wp;
  logic [4:0] cnt;
  assign fifo_dout  = mem[rp];
  assign fifo_empty = cnt == 0;
  assign fifo_full  = cnt == 16;
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) mem[i] <= 6'(i);
      rp <= 0; wp <= 0; cnt <= 16;
    end else begin
      if (fifo_ren) rp <= rp + 1;
      if (fifo_wen) begin mem[wp] <= fifo_din; wp <= wp + 1; end
      cnt <= cnt + 5'(fifo_wen) - 5'(fifo_ren);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    resetn = 0; alloc_req = 0; rel_req = 0; rel_tag0 = 0; rel_tag1 = 0; quiesce_req = 0;
    tick(); tick();
    resetn = 1;
  endtask
  initial begin
    do_reset();
    chk("rst_vld", 32'(alloc_vld), 0);
    chk("rst_tag", 32'(alloc_tag), 0);
    chk("rst_out", 32'(outstanding), 0);
    chk("rst_done", 32'(quiesce_done), 0);
    chk("rst_comb", {fifo_ren, fifo_wen, rel_ack, fifo_din}, 0);
    // sixteen single-requester allocations drain the pool in order
    alloc_req = 2'b01;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("seq_vld", 32'(alloc_vld), 1);
      chk("seq_tag", 32'(alloc_tag), 32'(i));
      chk("seq_out", 32'(outstanding), 32'(i + 1));
    end
    #1 chk("empty_ren", 32'(fifo_ren), 0);
    tick();
    chk("empty_vld", 32'(alloc_vld), 0);
    chk("empty_out", 32'(outstanding), 16);
    // two releasers collide; served one per cycle in round-robin order
    alloc_req = 0; rel_req = 2'b11; rel_tag0 = 5; rel_tag1 = 9;
    #1 chk("rel_ack0", 32'(rel_ack), 1);
    chk("rel_din0", 32'(fifo_din), 5);
    tick();
    chk("rel_out15", 32'(outstanding), 15);
    rel_req = 2'b10;
    #1 chk("rel_ack1", 32'(rel_ack), 2);
    chk("rel_din1", 32'(fifo_din), 9);
    tick();
    chk("rel_out14", 32'(outstanding), 14);
    rel_req = 0; alloc_req = 2'b01;
    tick();
    chk("back_tag5", 32'(alloc_tag), 5);
    tick();
    chk("back_tag9", 32'(alloc_tag), 9);
    chk("back_out", 32'(outstanding), 16);
    // both allocators alternate
    do_reset();
    alloc_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_vld", 32'(alloc_vld), (i % 2 == 0) ? 1 : 2);
      chk("rr_tag", 32'(alloc_tag), 32'(i));
    end
    chk("rr_out", 32'(outstanding), 4);
    // simultaneous pop and push keep outstanding unchanged
    alloc_req = 2'b01; rel_req = 2'b01; rel_tag0 = 2;
    #1 chk("pp_ren", 32'(fifo_ren), 1);
    chk("pp_wen", 32'(fifo_wen), 1);
    tick();
    chk("pp_out", 32'(outstanding), 4);
    chk("pp_vld", 32'(alloc_vld), 1);
    chk("pp_tag", 32'(alloc_tag), 4);
    alloc_req = 0; rel_tag0 = 0;
    tick();
    rel_tag0 = 1;
    tick();
    chk("q_out2", 32'(outstanding), 2);
    // quiesce blocks allocation immediately and completes when all tags are home
    rel_req = 0; quiesce_req = 1; alloc_req = 2'b11;
    #1 chk("q_ren", 32'(fifo_ren), 0);
    tick();
    chk("q_vld0", 32'(alloc_vld), 0);
    rel_req = 2'b01; rel_tag0 = 3;
    tick();
    chk("q_out1", 32'(outstanding), 1);
    rel_tag0 = 4;
    tick();
    chk("q_out0", 32'(outstanding), 0);
    chk("q_done0", 32'(quiesce_done), 0);
    rel_req = 0;
    tick();
    chk("q_done1", 32'(quiesce_done), 1);
    chk("q_vld1", 32'(alloc_vld), 0);
    tick();
    chk("q_hold", 32'(quiesce_done), 1);
    quiesce_req = 0;
    tick();
    chk("q_clr", 32'(quiesce_done), 0);
    chk("q_vld2", 32'(alloc_vld), 0);
    tick();
    chk("q_res_vld", 32'(alloc_vld), 2);
    chk("q_res_tag", 32'(alloc_tag), 5);
    // release into a full pool is refused
    do_reset();
    rel_req = 2'b01; rel_tag0 = 7;
    #1 chk("full_ack", 32'(rel_ack), 0);
    chk("full_wen", 32'(fifo_wen), 0);
    tick();
    chk("full_out", 32'(outstanding), 0);
`ifdef FREELIST_ARBITER_ERRCHK_EN
    chk("err_set", 32'(err_sticky), 1);
    rel_req = 0;
    tick();
    chk("err_hold", 32'(err_sticky), 1);
    do_reset();
    chk("err_clr", 32'(err_sticky), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
